// File: rtl/store_buffer_pkg.sv
// Shared constants for the store buffer: ALU op codes, default depth and
// the alignment rule, plus small helpers to classify an alucode.
package store_buffer_pkg;

  localparam logic [5:0] ALU_LB  = 6'h20;
  localparam logic [5:0] ALU_LH  = 6'h21;
  localparam logic [5:0] ALU_LW  = 6'h22;
  localparam logic [5:0] ALU_LBU = 6'h23;
  localparam logic [5:0] ALU_LHU = 6'h24;
  localparam logic [5:0] ALU_SB  = 6'h28;
  localparam logic [5:0] ALU_SH  = 6'h29;
  localparam logic [5:0] ALU_SW  = 6'h2A;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam int SB_DEPTH = 4;

  // A halfword may not straddle a word; a word must sit on a word boundary.
  localparam logic [1:0] HALF_BAD_OFFSET = 2'd3;
  localparam logic [1:0] WORD_OK_OFFSET  = 2'd0;

  function automatic logic is_load_code(logic [5:0] alucode);
    return (alucode == ALU_LB) || (alucode == ALU_LBU) || (alucode == ALU_LH) ||
           (alucode == ALU_LHU) || (alucode == ALU_LW);
  endfunction

  function automatic logic is_store_code(logic [5:0] alucode);
    return (alucode == ALU_SB) || (alucode == ALU_SH) || (alucode == ALU_SW);
  endfunction

  function automatic logic is_misaligned(logic [5:0] alucode, logic [1:0] offset);
    case (alucode)
      ALU_LH, ALU_LHU, ALU_SH: return offset == HALF_BAD_OFFSET;
      ALU_LW, ALU_SW:          return offset != WORD_OK_OFFSET;
      default:                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Execute-stage op bus into the store buffer; the execute stage is the
// master, the store buffer the slave that answers with in_ready.
interface store_buffer_if #(parameter int ADDR_W = 17);
  logic              in_valid;
  logic              in_ready;
  logic              in_is_load;
  logic              in_is_store;
  logic [5:0]        in_alucode;
  logic [ADDR_W-1:0] in_addr;
  logic [31:0]       in_wdata;

  modport master (output in_valid, in_is_load, in_is_store, in_alucode, in_addr, in_wdata,
                  input  in_ready);
  modport slave  (input  in_valid, in_is_load, in_is_store, in_alucode, in_addr, in_wdata,
                  output in_ready);
endinterface

// File: rtl/store_buffer_fifo.sv
// Pending-store storage: circular FIFO with per-entry valid bits and a
// word-address match vector used for load hazard detection.
module store_buffer_fifo import store_buffer_pkg::*; #(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = 17
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [ADDR_W-1:0]          push_addr,
  input  logic [5:0]                 push_alucode,
  input  logic [31:0]                push_wdata,
  input  logic [ADDR_W-3:0]          match_word,
  output logic [ADDR_W-1:0]          head_addr,
  output logic [5:0]                 head_alucode,
  output logic [31:0]                head_wdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic [$clog2(DEPTH)-1:0]   rd_ptr,
  output logic [DEPTH-1:0]           match_vec,
  output logic [DEPTH-1:0]           sw_vec,
  output logic [DEPTH-1:0][31:0]     entry_wdata
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]     wr_ptr;
  logic [DEPTH-1:0]  valid;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [5:0]        alu_q  [DEPTH];
  logic [31:0]       data_q [DEPTH];

  // When full, push and pop hit the same slot; the later push keeps it valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      valid  <= '0;
    end else begin
      if (pop) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + 1'b1;
      end
      if (push) begin
        valid[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= push_addr;
      alu_q[wr_ptr]  <= push_alucode;
      data_q[wr_ptr] <= push_wdata;
    end
  end

  always_comb begin
    match_vec   = '0;
    sw_vec      = '0;
    entry_wdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_vec[i]   = valid[i] && (addr_q[i][ADDR_W-1:2] == match_word);
      sw_vec[i]      = valid[i] && (alu_q[i] == ALU_SW);
      entry_wdata[i] = data_q[i];
    end
  end

  assign head_addr    = addr_q[rd_ptr];
  assign head_alucode = alu_q[rd_ptr];
  assign head_wdata   = data_q[rd_ptr];

endmodule

// File: rtl/store_buffer.sv
// Store buffer in front of data_memory: loads take the port first, queued
// stores drain in idle cycles. Optional load forwarding under STORE_FWD_EN.
module store_buffer import store_buffer_pkg::*; #(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  store_buffer_if.slave     op,
  input  logic              mem_wr_ready,
  output logic              mem_is_load,
  output logic              mem_is_store,
  output logic [5:0]        mem_alucode,
  output logic [ADDR_W-1:0] mem_r_addr,
  output logic [ADDR_W-1:0] mem_w_addr,
  output logic [31:0]       mem_w_data,
  output logic              load_issued,
  output logic              sb_empty,
  output logic              misalign_err,
  output logic [ADDR_W-1:0] misalign_addr,
  output logic              fwd_valid,
  output logic [31:0]       fwd_data
);

  localparam int             PW         = $clog2(DEPTH);
  localparam logic [PW:0]    FULL_COUNT = (PW+1)'(DEPTH);

  logic [ADDR_W-1:0]     head_addr;
  logic [5:0]            head_alucode;
  logic [31:0]           head_wdata;
  logic [PW:0]           count;
  logic [PW-1:0]         rd_ptr;
  logic [DEPTH-1:0]      match_vec;
  logic [DEPTH-1:0]      sw_vec;
  logic [DEPTH-1:0][31:0] entry_wdata;

  logic neither, illegal, misaligned, load_ok, store_ok;
  logic hazard, issue_load, drain, push, fwd_ok;

  store_buffer_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push         (push),
    .pop          (drain),
    .push_addr    (op.in_addr),
    .push_alucode (op.in_alucode),
    .push_wdata   (op.in_wdata),
    .match_word   (op.in_addr[ADDR_W-1:2]),
    .head_addr    (head_addr),
    .head_alucode (head_alucode),
    .head_wdata   (head_wdata),
    .count        (count),
    .rd_ptr       (rd_ptr),
    .match_vec    (match_vec),
    .sw_vec       (sw_vec),
    .entry_wdata  (entry_wdata)
  );

  assign neither    = !op.in_is_load && !op.in_is_store;
  assign illegal    = (op.in_is_load && op.in_is_store) ||
                      (op.in_is_load && !is_load_code(op.in_alucode)) ||
                      (op.in_is_store && !is_store_code(op.in_alucode));
  assign misaligned = !neither && !illegal && is_misaligned(op.in_alucode, op.in_addr[1:0]);
  assign load_ok    = op.in_valid && op.in_is_load && !illegal && !misaligned;
  assign store_ok   = op.in_valid && op.in_is_store && !illegal && !misaligned;

  // A load owns the port whenever it is free of hazards; drains fill the gaps.
  assign hazard     = |match_vec;
  assign issue_load = load_ok && !hazard;
  assign drain      = (count != '0) && mem_wr_ready && !issue_load;
  assign push       = store_ok && ((count != FULL_COUNT) || drain);

  assign op.in_ready = op.in_valid &&
                       (neither || illegal || misaligned || issue_load || fwd_ok || push);
  assign load_issued = issue_load;
  assign sb_empty    = (count == '0);

`ifdef STORE_FWD_EN
  logic [31:0] fwd_word;

  // Walk entries oldest to youngest so the last match wins.
  always_comb begin
    fwd_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (match_vec[rd_ptr + PW'(i)])
        fwd_word = entry_wdata[rd_ptr + PW'(i)];
    end
  end

  assign fwd_ok    = load_ok && hazard && (op.in_alucode == ALU_LW) &&
                     ((match_vec & ~sw_vec) == '0);
  assign fwd_valid = fwd_ok;
  assign fwd_data  = fwd_ok ? fwd_word : '0;
`else
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{rd_ptr, sw_vec, entry_wdata};
  assign fwd_ok    = 1'b0;
  assign fwd_valid = 1'b0;
  assign fwd_data  = '0;
`endif

  always_comb begin
    mem_is_load  = 1'b0;
    mem_is_store = 1'b0;
    mem_alucode  = '0;
    mem_r_addr   = '0;
    mem_w_addr   = '0;
    mem_w_data   = '0;
    if (issue_load) begin
      mem_is_load = 1'b1;
      mem_alucode = op.in_alucode;
      mem_r_addr  = op.in_addr;
    end else if (drain) begin
      mem_is_store = 1'b1;
      mem_alucode  = head_alucode;
      mem_w_addr   = head_addr;
      mem_w_data   = head_wdata;
    end
  end

  // Only the first rejected op is recorded; later ones leave the log intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_err  <= 1'b0;
      misalign_addr <= '0;
    end else if (op.in_valid && misaligned && !misalign_err) begin
      misalign_err  <= 1'b1;
      misalign_addr <= op.in_addr;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: a queue-based reference model predicts
// each cycle's response, a negedge monitor compares it against the DUT.
module tb_store_buffer;
  import store_buffer_pkg::*;

  localparam int ADDR_W = 17;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic mem_wr_ready;
  logic mem_is_load, mem_is_store, load_issued, sb_empty, misalign_err, fwd_valid;
  logic [5:0] mem_alucode;
  logic [ADDR_W-1:0] mem_r_addr, mem_w_addr, misalign_addr;
  logic [31:0] mem_w_data, fwd_data;

  always #5 clk = ~clk;

  store_buffer_if #(.ADDR_W(ADDR_W)) op ();

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .op            (op),
    .mem_wr_ready  (mem_wr_ready),
    .mem_is_load   (mem_is_load),
    .mem_is_store  (mem_is_store),
    .mem_alucode   (mem_alucode),
    .mem_r_addr    (mem_r_addr),
    .mem_w_addr    (mem_w_addr),
    .mem_w_data    (mem_w_data),
    .load_issued   (load_issued),
    .sb_empty      (sb_empty),
    .misalign_err  (misalign_err),
    .misalign_addr (misalign_addr),
    .fwd_valid     (fwd_valid),
    .fwd_data      (fwd_data)
  );

  typedef struct {
    logic [5:0]        alu;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } st_t;

  typedef struct {
    bit                ready, ld, st, fwd, empty, merr;
    logic [5:0]        ld_alu, st_alu;
    logic [ADDR_W-1:0] ld_addr, st_addr, maddr;
    logic [31:0]       ld_data, st_data, fwd_data;
  } exp_t;

  st_t  pq[$];
  exp_t exp_q[$];
  exp_t me;
  bit   m_merr;
  logic [ADDR_W-1:0] m_maddr;
  logic [7:0] ref_mem [256];
  logic [7:0] dut_mem [256];
  int checks = 0;
  int failures = 0;
  bit r;

  function automatic int op_size(logic [5:0] a);
    if (a == ALU_LB || a == ALU_LBU || a == ALU_SB) return 1;
    if (a == ALU_LH || a == ALU_LHU || a == ALU_SH) return 2;
    if (a == ALU_LW || a == ALU_SW) return 4;
    return 0;
  endfunction

  function automatic bit code_is_load(logic [5:0] a);
    return a inside {ALU_LB, ALU_LBU, ALU_LH, ALU_LHU, ALU_LW};
  endfunction

  function automatic bit code_is_store(logic [5:0] a);
    return a inside {ALU_SB, ALU_SH, ALU_SW};
  endfunction

  function automatic logic [7:0] rd_byte(bit use_dut, int unsigned idx);
    return use_dut ? dut_mem[idx & 255] : ref_mem[idx & 255];
  endfunction

  function automatic logic [31:0] mem_read(bit use_dut, logic [5:0] a, logic [ADDR_W-1:0] addr);
    int unsigned b = int'(addr[7:0]);
    logic [7:0] m0, m1, m2, m3;
    m0 = rd_byte(use_dut, b);
    m1 = rd_byte(use_dut, b + 1);
    m2 = rd_byte(use_dut, b + 2);
    m3 = rd_byte(use_dut, b + 3);
    case (a)
      ALU_LB:  return {{24{m0[7]}}, m0};
      ALU_LBU: return {24'h0, m0};
      ALU_LH:  return {{16{m1[7]}}, m1, m0};
      ALU_LHU: return {16'h0, m1, m0};
      default: return {m3, m2, m1, m0};
    endcase
  endfunction

  task automatic mem_write(bit use_dut, logic [5:0] a, logic [ADDR_W-1:0] addr, logic [31:0] d);
    int unsigned b = int'(addr[7:0]);
    for (int k = 0; k < op_size(a); k++) begin
      if (use_dut) dut_mem[(b + k) & 255] = d[8*k +: 8];
      else         ref_mem[(b + k) & 255] = d[8*k +: 8];
    end
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic drive_idle();
    op.in_valid = 1'b0; op.in_is_load = 1'b0; op.in_is_store = 1'b0;
    op.in_alucode = '0; op.in_addr = '0; op.in_wdata = '0;
  endtask

  task automatic push_reset_exp();
    exp_t e;
    e.ready = 0; e.ld = 0; e.st = 0; e.fwd = 0; e.empty = 1; e.merr = 0;
    e.ld_alu = '0; e.st_alu = '0; e.ld_addr = '0; e.st_addr = '0; e.maddr = '0;
    e.ld_data = '0; e.st_data = '0; e.fwd_data = '0;
    exp_q.push_back(e);
  endtask

  task automatic do_reset(int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      rst_n = 1'b0;
      drive_idle();
      mem_wr_ready = 1'b0;
      pq.delete();
      m_merr = 0;
      m_maddr = '0;
      push_reset_exp();
    end
  endtask

  // One cycle: drive the op, predict the response from the pending-store list.
  task automatic applyStimulus(input bit v, input bit ld, input bit st, input logic [5:0] alu,
                               input logic [ADDR_W-1:0] addr, input logic [31:0] data,
                               input bit wr, output bit rdy);
    exp_t e;
    st_t  head, ent;
    bit   can_drain, push_it, hz, all_sw, use_fwd;
    logic [31:0] fd;
    @(posedge clk); #1;
    rst_n = 1'b1;
    op.in_valid = v; op.in_is_load = ld; op.in_is_store = st;
    op.in_alucode = alu; op.in_addr = addr; op.in_wdata = data;
    mem_wr_ready = wr;
    e.ready = 0; e.ld = 0; e.st = 0; e.fwd = 0;
    e.ld_alu = '0; e.st_alu = '0; e.ld_addr = '0; e.st_addr = '0;
    e.ld_data = '0; e.st_data = '0; e.fwd_data = '0;
    e.empty = (pq.size() == 0); e.merr = m_merr; e.maddr = m_maddr;
    can_drain = (pq.size() > 0) && wr;
    push_it = 0;
    if (!v) begin
      e.ready = 0;
    end else if ((ld && st) || (!ld && !st)) begin
      e.ready = 1;
    end else if ((ld && !code_is_load(alu)) || (st && !code_is_store(alu))) begin
      e.ready = 1;
    end else if ((int'(addr[1:0]) + op_size(alu)) > 4) begin
      e.ready = 1;
      if (!m_merr) begin m_merr = 1; m_maddr = addr; end
    end else if (ld) begin
      hz = 0; all_sw = 1; fd = '0;
      foreach (pq[i]) begin
        ent = pq[i];
        if (ent.addr[ADDR_W-1:2] == addr[ADDR_W-1:2]) begin
          hz = 1;
          if (ent.alu != ALU_SW) all_sw = 0;
          fd = ent.data;
        end
      end
      use_fwd = 0;
`ifdef STORE_FWD_EN
      use_fwd = hz && all_sw && (alu == ALU_LW);
`endif
      if (!hz) begin
        e.ready = 1; e.ld = 1; e.ld_alu = alu; e.ld_addr = addr;
        e.ld_data = mem_read(0, alu, addr);
        can_drain = 0;
      end else if (use_fwd) begin
        e.ready = 1; e.fwd = 1; e.fwd_data = fd;
      end
    end else begin
      e.ready = (pq.size() < DEPTH) || can_drain;
      push_it = e.ready;
    end
    if (can_drain) begin
      head = pq.pop_front();
      e.st = 1; e.st_alu = head.alu; e.st_addr = head.addr; e.st_data = head.data;
      mem_write(0, head.alu, head.addr, head.data);
    end
    if (push_it) begin
      ent.alu = alu; ent.addr = addr; ent.data = data;
      pq.push_back(ent);
    end
    exp_q.push_back(e);
    rdy = e.ready;
  endtask

  task automatic checkOutput(exp_t e);
    check("in_ready", 32'(op.in_ready), 32'(e.ready));
    check("mem_is_load", 32'(mem_is_load), 32'(e.ld));
    check("mem_is_store", 32'(mem_is_store), 32'(e.st));
    check("load_issued", 32'(load_issued), 32'(e.ld));
    check("fwd_valid", 32'(fwd_valid), 32'(e.fwd));
    check("sb_empty", 32'(sb_empty), 32'(e.empty));
    check("misalign_err", 32'(misalign_err), 32'(e.merr));
    check("misalign_addr", 32'(misalign_addr), 32'(e.maddr));
    if (e.ld) begin
      check("load_alucode", 32'(mem_alucode), 32'(e.ld_alu));
      check("load_r_addr", 32'(mem_r_addr), 32'(e.ld_addr));
      check("load_data", mem_read(1, mem_alucode, mem_r_addr), e.ld_data);
    end
    if (e.st) begin
      check("store_alucode", 32'(mem_alucode), 32'(e.st_alu));
      check("store_w_addr", 32'(mem_w_addr), 32'(e.st_addr));
      check("store_w_data", mem_w_data, e.st_data);
    end
    if (e.fwd) check("fwd_data", fwd_data, e.fwd_data);
`ifndef STORE_FWD_EN
    check("fwd_data_zero", fwd_data, 32'h0);
`endif
    if (mem_is_store) mem_write(1, mem_alucode, mem_w_addr, mem_w_data);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      me = exp_q.pop_front();
      checkOutput(me);
    end
  end

  logic [5:0] ld_codes [5] = '{ALU_LB, ALU_LBU, ALU_LH, ALU_LHU, ALU_LW};
  logic [5:0] st_codes [3] = '{ALU_SB, ALU_SH, ALU_SW};
  logic [5:0] all_codes [8] = '{ALU_LB, ALU_LBU, ALU_LH, ALU_LHU, ALU_LW, ALU_SB, ALU_SH, ALU_SW};

  initial begin
    int tries;
    int kind;
    bit v, ld, st;
    logic [5:0] alu;
    rst_n = 1'b0;
    mem_wr_ready = 1'b0;
    drive_idle();
    m_merr = 0;
    m_maddr = '0;
    for (int i = 0; i < 256; i++) begin ref_mem[i] = 8'h0; dut_mem[i] = 8'h0; end
    do_reset(2);

    // Reset while stores are still queued: they must vanish.
    applyStimulus(1, 0, 1, ALU_SW, 'h10, 32'hDEADBEEF, 0, r);
    applyStimulus(1, 0, 1, ALU_SW, 'h14, 32'h1, 0, r);
    applyStimulus(0, 0, 0, '0, '0, '0, 0, r);
    do_reset(2);
    repeat (3) applyStimulus(0, 0, 0, '0, '0, '0, 1, r);
    applyStimulus(1, 1, 0, ALU_LW, 'h10, '0, 1, r);

    // Load priority over a pending store.
    applyStimulus(1, 0, 1, ALU_SW, 'h20, 32'hA5A5A5A5, 0, r);
    applyStimulus(1, 1, 0, ALU_LW, 'h40, '0, 1, r);
    applyStimulus(0, 0, 0, '0, '0, '0, 1, r);

    // Byte store hazard stalls a load to the same word.
    applyStimulus(1, 0, 1, ALU_SB, 'h31, 32'h7F, 0, r);
    applyStimulus(1, 1, 0, ALU_LBU, 'h30, '0, 0, r);
    applyStimulus(1, 1, 0, ALU_LBU, 'h30, '0, 0, r);
    tries = 0;
    do begin
      applyStimulus(1, 1, 0, ALU_LBU, 'h30, '0, 1, r);
      tries++;
    end while (!r && tries < 8);
    applyStimulus(1, 1, 0, ALU_LW, 'h30, '0, 1, r);

    // Fill, reject a fifth, then push-and-drain in one cycle.
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 0, 1, ALU_SW, 17'(32'h80 + 4*i), 32'hC0DE0000 + i, 0, r);
    applyStimulus(1, 0, 1, ALU_SW, 'h90, 32'hC0DE0004, 0, r);
    applyStimulus(1, 0, 1, ALU_SW, 'h90, 32'hC0DE0004, 1, r);
    repeat (6) applyStimulus(0, 0, 0, '0, '0, '0, 1, r);
    applyStimulus(1, 1, 0, ALU_LW, 'h80, '0, 1, r);
    applyStimulus(1, 1, 0, ALU_LW, 'h90, '0, 1, r);

    // Misaligned ops are consumed and logged once.
    applyStimulus(1, 0, 1, ALU_SH, 'h03, 32'hFFFF, 1, r);
    applyStimulus(1, 1, 0, ALU_LW, 'h06, '0, 1, r);
    applyStimulus(0, 0, 0, '0, '0, '0, 1, r);

    // Word load after a word store to the same address.
    applyStimulus(1, 0, 1, ALU_SW, 'h50, 32'h12345678, 0, r);
    applyStimulus(1, 1, 0, ALU_LW, 'h50, '0, 0, r);
    tries = 0;
    do begin
      applyStimulus(1, 1, 0, ALU_LW, 'h50, '0, 1, r);
      tries++;
    end while (!r && tries < 8);

    // Illegal combinations are swallowed.
    applyStimulus(1, 1, 1, ALU_LW, 'h60, '0, 1, r);
    applyStimulus(1, 1, 0, ALU_SW, 'h60, '0, 1, r);
    applyStimulus(1, 0, 1, ALU_LB, 'h60, '0, 1, r);
    applyStimulus(1, 0, 0, ALU_SW, 'h60, '0, 1, r);

    for (int n = 0; n < 800; n++) begin
      if (n == 400) do_reset(1);
      kind = $urandom_range(0, 19);
      v  = ($urandom_range(0, 7) != 0);
      ld = (kind < 9) || (kind == 18);
      st = ((kind >= 9) && (kind < 18)) || (kind == 18);
      if (ld && !st)      alu = ld_codes[$urandom_range(0, 4)];
      else if (st && !ld) alu = st_codes[$urandom_range(0, 2)];
      else                alu = all_codes[$urandom_range(0, 7)];
      if ($urandom_range(0, 19) == 0) alu = all_codes[$urandom_range(0, 7)];
      applyStimulus(v, ld, st, alu, 17'($urandom_range(0, 63)), $urandom,
                    $urandom_range(0, 3) != 0, r);
    end
    repeat (6) applyStimulus(0, 0, 0, '0, '0, '0, 1, r);

    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
